wb_arb2: RTL and testbench

WB_ARB2 -- requirements
Module: wb_arb2

---
 rtl/wb_arb2.sv | 166 ++++++++++++++++
 tb/tb_wb_arb2.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arb2.sv
// Two-master Wishbone arbiter onto one shared slave port: fair tie-breaking,
// lock support, and a watchdog that errors out transfers the slave never terminates.
module wb_arb2 #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              CLK_I,
    input  logic              RST_I,

    input  logic              M0_CYC_I,
    input  logic              M0_STB_I,
    input  logic              M0_WE_I,
    input  logic              M0_LOCK_I,
    input  logic [AW-1:0]     M0_ADR_I,
    input  logic [DW-1:0]     M0_DAT_I,
    input  logic [DW/8-1:0]   M0_SEL_I,
    output logic              M0_ACK_O,
    output logic              M0_ERR_O,
    output logic              M0_RTY_O,
    output logic [DW-1:0]     M0_DAT_O,

    input  logic              M1_CYC_I,
    input  logic              M1_STB_I,
    input  logic              M1_WE_I,
    input  logic              M1_LOCK_I,
    input  logic [AW-1:0]     M1_ADR_I,
    input  logic [DW-1:0]     M1_DAT_I,
    input  logic [DW/8-1:0]   M1_SEL_I,
    output logic              M1_ACK_O,
    output logic              M1_ERR_O,
    output logic              M1_RTY_O,
    output logic [DW-1:0]     M1_DAT_O,

    output logic              S_CYC_O,
    output logic              S_STB_O,
    output logic              S_WE_O,
    output logic              S_LOCK_O,
    output logic [AW-1:0]     S_ADR_O,
    output logic [DW-1:0]     S_DAT_O,
    output logic [DW/8-1:0]   S_SEL_O,
    input  logic              S_ACK_I,
    input  logic              S_ERR_I,
    input  logic              S_RTY_I,
    input  logic [DW-1:0]     S_DAT_I,

    output logic [1:0]        GNT_O
);

    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TOUT  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic          gidx, gidx_nxt;
    logic          ptr, ptr_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    logic            g_cyc, g_stb, g_we, g_lock;
    logic [AW-1:0]   g_adr;
    logic [DW-1:0]   g_dat;
    logic [DW/8-1:0] g_sel;
    logic            any_req, win, term, in_grant;

    // Granted master's request lines
    assign g_cyc  = gidx ? M1_CYC_I  : M0_CYC_I;
    assign g_stb  = gidx ? M1_STB_I  : M0_STB_I;
    assign g_we   = gidx ? M1_WE_I   : M0_WE_I;
    assign g_lock = gidx ? M1_LOCK_I : M0_LOCK_I;
    assign g_adr  = gidx ? M1_ADR_I  : M0_ADR_I;
    assign g_dat  = gidx ? M1_DAT_I  : M0_DAT_I;
    assign g_sel  = gidx ? M1_SEL_I  : M0_SEL_I;

    // On a tie the master that did not win last time gets the bus
    assign any_req  = M0_CYC_I | M1_CYC_I;
    assign win      = (M0_CYC_I & M1_CYC_I) ? ~ptr : M1_CYC_I;
    assign term     = S_ACK_I | S_ERR_I | S_RTY_I;
    assign in_grant = (state == GRANT);

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state <= IDLE;
            gidx  <= 1'b0;
            ptr   <= 1'b1;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            gidx  <= gidx_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gidx_nxt  = gidx;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (any_req) begin
                    state_nxt = GRANT;
                    gidx_nxt  = win;
                    ptr_nxt   = win;
                end
            end
            GRANT: begin
                if (!g_cyc && !g_lock) begin
                    // Release; the other master (if waiting) takes over at this edge
                    cnt_nxt = '0;
                    if (any_req) begin
                        gidx_nxt = win;
                        ptr_nxt  = win;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (term) begin
                    cnt_nxt = '0;
                end else if ((TIMEOUT != 0) && g_cyc && g_stb) begin
                    if (cnt == CNT_LAST) begin
                        state_nxt = TOUT;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            TOUT: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Slave port follows the granted master only while in GRANT
    assign S_CYC_O  = in_grant & g_cyc;
    assign S_STB_O  = in_grant & g_stb;
    assign S_WE_O   = in_grant & g_we;
    assign S_LOCK_O = in_grant & g_lock;
    assign S_ADR_O  = in_grant ? g_adr : '0;
    assign S_DAT_O  = in_grant ? g_dat : '0;
    assign S_SEL_O  = in_grant ? g_sel : '0;

    assign GNT_O = (state == IDLE) ? 2'b00 : (gidx ? 2'b10 : 2'b01);

    assign M0_ACK_O = in_grant & ~gidx & S_ACK_I;
    assign M0_RTY_O = in_grant & ~gidx & S_RTY_I;
    assign M0_ERR_O = ~gidx & ((in_grant & S_ERR_I) | (state == TOUT));
    assign M1_ACK_O = in_grant & gidx & S_ACK_I;
    assign M1_RTY_O = in_grant & gidx & S_RTY_I;
    assign M1_ERR_O = gidx & ((in_grant & S_ERR_I) | (state == TOUT));

    assign M0_DAT_O = GNT_O[0] ? S_DAT_I : '0;
    assign M1_DAT_O = GNT_O[1] ? S_DAT_I : '0;

endmodule

// File: tb/tb_wb_arb2.sv
// Bench for wb_arb2: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a bus-ownership model.
module tb_wb_arb2;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]    cyc, stb, we, lock;
    logic [AW-1:0] adr[2];
    logic [DW-1:0] wdat[2];
    logic [SW-1:0] sel[2];
    logic          s_ack, s_err, s_rty;
    logic [DW-1:0] s_dat;

    wire           m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
    wire [DW-1:0]  m0_dat, m1_dat;
    wire           s_cyc_o, s_stb_o, s_we_o, s_lock_o;
    wire [AW-1:0]  s_adr_o;
    wire [DW-1:0]  s_dat_o;
    wire [SW-1:0]  s_sel_o;
    wire [1:0]     gnt;

    wb_arb2 #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .CLK_I(clk), .RST_I(rst),
        .M0_CYC_I(cyc[0]), .M0_STB_I(stb[0]), .M0_WE_I(we[0]), .M0_LOCK_I(lock[0]),
        .M0_ADR_I(adr[0]), .M0_DAT_I(wdat[0]), .M0_SEL_I(sel[0]),
        .M0_ACK_O(m0_ack), .M0_ERR_O(m0_err), .M0_RTY_O(m0_rty), .M0_DAT_O(m0_dat),
        .M1_CYC_I(cyc[1]), .M1_STB_I(stb[1]), .M1_WE_I(we[1]), .M1_LOCK_I(lock[1]),
        .M1_ADR_I(adr[1]), .M1_DAT_I(wdat[1]), .M1_SEL_I(sel[1]),
        .M1_ACK_O(m1_ack), .M1_ERR_O(m1_err), .M1_RTY_O(m1_rty), .M1_DAT_O(m1_dat),
        .S_CYC_O(s_cyc_o), .S_STB_O(s_stb_o), .S_WE_O(s_we_o), .S_LOCK_O(s_lock_o),
        .S_ADR_O(s_adr_o), .S_DAT_O(s_dat_o), .S_SEL_O(s_sel_o),
        .S_ACK_I(s_ack), .S_ERR_I(s_err), .S_RTY_I(s_rty), .S_DAT_I(s_dat),
        .GNT_O(gnt)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model: who owns the bus (-1 none), who won last, how many silent active
    // cycles have elapsed, and whether this cycle is the forced-error cycle.
    int owner, last, silent;
    bit tout;

    function automatic int pick(input int prev);
        if (cyc[0] && cyc[1]) return (prev == 0) ? 1 : 0;
        return cyc[1] ? 1 : 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            owner  <= -1;
            last   <= 1;
            silent <= 0;
            tout   <= 1'b0;
        end else begin
            int o, l, s;
            bit t;
            o = owner; l = last; s = silent; t = tout;
            if (t) begin
                t = 1'b0; o = -1; s = 0;
            end else if (o < 0) begin
                if (|cyc) begin o = pick(l); l = o; s = 0; end
            end else if (!cyc[o] && !lock[o]) begin
                s = 0;
                if (|cyc) begin o = pick(l); l = o; end
                else o = -1;
            end else if (s_ack || s_err || s_rty) begin
                s = 0;
            end else if (cyc[o] && stb[o] && TO != 0) begin
                s = s + 1;
                if (s == TO) begin t = 1'b1; s = 0; end
            end
            owner  <= o;
            last   <= l;
            silent <= s;
            tout   <= t;
        end
    end

    // Every-cycle comparison against the model, away from the rising edge
    always @(negedge clk) begin
        int i;
        bit granted;
        logic [1:0]  eg;
        logic [71:0] es;
        logic [69:0] em;
        granted = (owner >= 0) && !tout;
        i  = (owner < 0) ? 0 : owner;
        eg = (owner < 0) ? 2'b00 : ((owner == 0) ? 2'b01 : 2'b10);
        es = granted ? {cyc[i], stb[i], we[i], lock[i], adr[i], wdat[i], sel[i]} : 72'h0;
        em = {granted && owner == 0 && s_ack,
              (granted && owner == 0 && s_err) || (tout && owner == 0),
              granted && owner == 0 && s_rty,
              (owner == 0) ? s_dat : 32'h0,
              granted && owner == 1 && s_ack,
              (granted && owner == 1 && s_err) || (tout && owner == 1),
              granted && owner == 1 && s_rty,
              (owner == 1) ? s_dat : 32'h0};
        chk("model_gnt", 128'(gnt), 128'(eg));
        chk("model_slave", 128'({s_cyc_o, s_stb_o, s_we_o, s_lock_o, s_adr_o, s_dat_o, s_sel_o}), 128'(es));
        chk("model_master", 128'({m0_ack, m0_err, m0_rty, m0_dat, m1_ack, m1_err, m1_rty, m1_dat}), 128'(em));
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic sample();
        @(negedge clk); #1;
    endtask

    task automatic idle_all();
        cyc = '0; stb = '0; we = '0; lock = '0;
        for (int n = 0; n < 2; n++) begin adr[n] = '0; wdat[n] = '0; sel[n] = '0; end
        s_ack = 0; s_err = 0; s_rty = 0; s_dat = '0;
    endtask

    int mode;

    initial begin
        idle_all();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", 128'(gnt), 128'(2'b00));
        chk("rst_scyc", 128'({s_cyc_o, s_stb_o, s_adr_o}), 128'h0);
        chk("rst_mterm", 128'({m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty}), 128'h0);
        rst = 1'b0;
        tick();

        // Single M0 write, slave acks two cycles after strobe
        cyc[0] = 1; stb[0] = 1; we[0] = 1; adr[0] = 32'h10; wdat[0] = 32'hA5A5A5A5; sel[0] = 4'hF;
        sample();
        chk("wr_gnt_before", 128'(gnt), 128'(2'b00));
        tick();
        sample();
        chk("wr_gnt", 128'(gnt), 128'(2'b01));
        chk("wr_adr", 128'(s_adr_o), 128'(32'h10));
        chk("wr_dat", 128'(s_dat_o), 128'(32'hA5A5A5A5));
        tick();
        tick();
        s_ack = 1;
        sample();
        chk("wr_m0_ack", 128'(m0_ack), 128'(1));
        chk("wr_m1_ack", 128'(m1_ack), 128'(0));
        tick();
        s_ack = 0; cyc[0] = 0; stb[0] = 0; we[0] = 0;
        sample();
        chk("wr_ack_once", 128'(m0_ack), 128'(0));
        tick();
        sample();
        chk("wr_released", 128'(gnt), 128'(2'b00));

        // Tie after reset, handoff, and tie again
        rst = 1; tick(); rst = 0;
        cyc = 2'b11;
        tick(); sample();
        chk("tie1_gnt", 128'(gnt), 128'(2'b01));
        cyc[0] = 0;
        tick(); sample();
        chk("handoff_gnt", 128'(gnt), 128'(2'b10));
        cyc[1] = 0;
        tick(); sample();
        chk("idle_gnt", 128'(gnt), 128'(2'b00));
        cyc = 2'b11;
        tick(); sample();
        chk("tie2_gnt", 128'(gnt), 128'(2'b01));

        // Lock holds the grant while M1 waits
        lock[0] = 1; cyc[0] = 0;
        tick(); sample();
        chk("lock_hold1", 128'(gnt), 128'(2'b01));
        tick(); sample();
        chk("lock_hold2", 128'(gnt), 128'(2'b01));
        lock[0] = 0;
        tick(); sample();
        chk("lock_release", 128'(gnt), 128'(2'b10));
        cyc[1] = 0;
        tick();

        // Watchdog: M1 active, slave silent
        cyc[1] = 1; stb[1] = 1;
        tick();
        for (int c = 1; c <= 8; c++) begin
            sample();
            chk("wd_no_err", 128'({m1_err, s_cyc_o}), 128'(2'b01));
            tick();
        end
        sample();
        chk("wd_err", 128'({m1_err, s_cyc_o, s_stb_o}), 128'(3'b100));
        chk("wd_gnt", 128'(gnt), 128'(2'b10));
        tick(); sample();
        chk("wd_idle", 128'(gnt), 128'(2'b00));
        cyc[1] = 0; stb[1] = 0;
        tick(); tick();

        // M0 read with retry and read data routing
        cyc[0] = 1; stb[0] = 1; we[0] = 0;
        tick();
        s_rty = 1; s_dat = 32'h1234;
        sample();
        chk("rty_m0", 128'({m0_rty, m0_dat}), 128'({1'b1, 32'h1234}));
        chk("rty_m1", 128'({m1_rty, m1_dat}), 128'h0);
        tick();
        s_rty = 0;
        sample();
        chk("rty_once", 128'(m0_rty), 128'(0));
        cyc[0] = 0; stb[0] = 0; s_dat = '0;
        tick(); tick();

        // Reset in the middle of an M1 transfer
        cyc[1] = 1; stb[1] = 1;
        tick(); sample();
        chk("mid_gnt", 128'(gnt), 128'(2'b10));
        rst = 1; #1;
        chk("mid_rst", 128'({gnt, s_cyc_o, m1_ack, m1_err, m1_rty}), 128'h0);
        tick();
        cyc[1] = 0; stb[1] = 0; cyc[0] = 1; stb[0] = 1;
        sample();
        rst = 0;
        tick(); sample();
        chk("post_rst_gnt", 128'(gnt), 128'(2'b01));
        idle_all();
        tick(); tick();

        // Random traffic
        mode = 1;
        for (int k = 0; k < 3000; k++) begin
            tick();
            if (rst) rst = 0;
            else if ($urandom_range(0, 599) == 0) rst = 1;
            for (int n = 0; n < 2; n++) begin
                if ($urandom_range(0, 9) == 0) cyc[n] = ~cyc[n];
                stb[n]  = cyc[n] && ($urandom_range(0, 3) != 0);
                we[n]   = 1'($urandom);
                lock[n] = ($urandom_range(0, 7) == 0);
                adr[n]  = $urandom;
                wdat[n] = $urandom;
                sel[n]  = 4'($urandom);
            end
            if ($urandom_range(0, 63) == 0) mode = $urandom_range(0, 2);
            s_ack = 0; s_err = 0; s_rty = 0;
            if ((mode == 1 && $urandom_range(0, 7) == 0) || (mode == 2 && $urandom_range(0, 1) == 0)) begin
                case ($urandom_range(0, 2))
                    0: s_ack = 1;
                    1: s_err = 1;
                    default: s_rty = 1;
                endcase
            end
            s_dat = $urandom;
        end
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
